mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues one data-memory request per load/store, stalls the pipe until ack or timeout.
// Latency: non-memory ops reach write-back 1 cycle after M entry; memory ops take at least 2 cycles.
// Backpressure: stallM (combinational) holds fetch..M while a request is outstanding; timeout aborts with sticky mem_err.
//
// Ports:
//   clk, reset (sync, active-low)
//   valid_m, MemWriteM, MemToRegM, RegWriteM, destAddM, alu_resultM, store_dataM : M-stage slot
//   dmem_req, dmem_we, dmem_addr, dmem_wdata / dmem_ack, dmem_rdata            : data-memory port
//   stallM                                                                       : pipeline freeze
//   wb_valid, wb_RegWrite, wb_MemToReg, wb_destAdd, wb_MemReadData, wb_alu_result: registered WB bundle
//   mem_err                                                                      : sticky timeout flag
module mem_stage_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_m,
    input  logic              MemWriteM,
    input  logic              MemToRegM,
    input  logic              RegWriteM,
    input  logic [3:0]        destAddM,
    input  logic [15:0]       alu_resultM,
    input  logic [15:0]       store_dataM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [15:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [15:0]       dmem_rdata,
    output logic              stallM,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic              wb_MemToReg,
    output logic [3:0]        wb_destAdd,
    output logic [15:0]       wb_MemReadData,
    output logic [15:0]       wb_alu_result,
    output logic              mem_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0] state;
    logic [7:0] cnt;
    logic       memop;
    logic       last_wait;

    // A slot with both strobes set is a store; dmem_we picks up MemWriteM directly.
    assign memop     = valid_m & (MemWriteM | MemToRegM);
    assign last_wait = (cnt == 8'(TIMEOUT - 1));

    // Release the stall in the cycle the request resolves (ack or final timeout cycle)
    // so the M instruction advances on the same edge the WB bundle is loaded.
    always_comb begin
        stallM = 1'b0;
        if (reset) begin
            if (state == S_IDLE)
                stallM = memop;
            else
                stallM = ~dmem_ack & ~last_wait;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            cnt            <= 8'd0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= 16'd0;
            wb_valid       <= 1'b0;
            wb_RegWrite    <= 1'b0;
            wb_MemToReg    <= 1'b0;
            wb_destAdd     <= 4'd0;
            wb_MemReadData <= 16'd0;
            wb_alu_result  <= 16'd0;
            mem_err        <= 1'b0;
        end else if (state == S_IDLE) begin
            if (memop) begin
                state      <= S_WAIT;
                cnt        <= 8'd0;
                dmem_req   <= 1'b1;
                dmem_we    <= MemWriteM;
                dmem_addr  <= alu_resultM[ADDR_W-1:0];
                dmem_wdata <= store_dataM;
                wb_valid   <= 1'b0;
            end else begin
                wb_valid       <= valid_m;
                wb_RegWrite    <= RegWriteM;
                wb_MemToReg    <= MemToRegM;
                wb_destAdd     <= destAddM;
                wb_alu_result  <= alu_resultM;
                wb_MemReadData <= 16'd0;
            end
        end else begin
            // M inputs are frozen by stallM while waiting, so they still describe this op.
            if (dmem_ack) begin
                state          <= S_IDLE;
                dmem_req       <= 1'b0;
                wb_valid       <= 1'b1;
                wb_RegWrite    <= RegWriteM;
                wb_MemToReg    <= MemToRegM;
                wb_destAdd     <= destAddM;
                wb_alu_result  <= alu_resultM;
                wb_MemReadData <= dmem_we ? 16'd0 : dmem_rdata;
            end else if (last_wait) begin
                // Abort: retire the slot but suppress the register write.
                state          <= S_IDLE;
                dmem_req       <= 1'b0;
                mem_err        <= 1'b1;
                wb_valid       <= 1'b1;
                wb_RegWrite    <= 1'b0;
                wb_MemToReg    <= MemToRegM;
                wb_destAdd     <= destAddM;
                wb_alu_result  <= alu_resultM;
                wb_MemReadData <= 16'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m, MemWriteM, MemToRegM, RegWriteM;
    logic [3:0]  destAddM;
    logic [15:0] alu_resultM, store_dataM;
    logic        dmem_req, dmem_we;
    logic [11:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        stallM;
    logic        wb_valid, wb_RegWrite, wb_MemToReg;
    logic [3:0]  wb_destAdd;
    logic [15:0] wb_MemReadData, wb_alu_result;
    logic        mem_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ADDR_W(12), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .valid_m(valid_m), .MemWriteM(MemWriteM), .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
        .destAddM(destAddM), .alu_resultM(alu_resultM), .store_dataM(store_dataM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stallM(stallM),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
        .wb_destAdd(wb_destAdd), .wb_MemReadData(wb_MemReadData), .wb_alu_result(wb_alu_result),
        .mem_err(mem_err)
    );

    typedef struct {
        logic        v, mw, mr, rw;
        logic [3:0]  dest;
        logic [15:0] alu;
        logic        exp_stall;
        logic        exp_wbv;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_m = 0; MemWriteM = 0; MemToRegM = 0; RegWriteM = 0;
        destAddM = 0; alu_resultM = 0; store_dataM = 0; dmem_ack = 0;
    endtask

    task automatic set_op(input logic mw, input logic mr, input logic rw,
                          input logic [3:0] d, input logic [15:0] a, input logic [15:0] sd);
        valid_m = 1; MemWriteM = mw; MemToRegM = mr; RegWriteM = rw;
        destAddM = d; alu_resultM = a; store_dataM = sd;
    endtask

    initial begin
        int stalls;
        int reqs;

        vecs[0] = '{1, 0, 0, 1, 4'h3, 16'h1234, 0, 1};
        vecs[1] = '{0, 0, 0, 1, 4'h7, 16'hAAAA, 0, 0};
        vecs[2] = '{0, 1, 0, 0, 4'h2, 16'h0100, 0, 0};
        vecs[3] = '{0, 0, 1, 1, 4'h4, 16'h0200, 0, 0};
        vecs[4] = '{1, 0, 0, 0, 4'hF, 16'hFFFF, 0, 1};

        // Reset, with a memop presented: stall must stay low while held in reset.
        idle_inputs();
        dmem_rdata = 16'h0;
        reset = 0;
        set_op(1, 0, 1, 4'h1, 16'h0010, 16'h5555);
        tick();
        chk("rst_stall", stallM, 0);
        tick();
        chk("rst_req", dmem_req, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wbalu", wb_alu_result, 0);
        idle_inputs();
        reset = 1;
        tick();

        // Non-memory slots: single-cycle pass-through, never stall.
        for (int i = 0; i < 5; i++) begin
            valid_m = vecs[i].v; MemWriteM = vecs[i].mw; MemToRegM = vecs[i].mr;
            RegWriteM = vecs[i].rw; destAddM = vecs[i].dest; alu_resultM = vecs[i].alu;
            dmem_rdata = 16'h7777;
            #1;
            chk($sformatf("v%0d_stall", i), stallM, vecs[i].exp_stall);
            tick();
            chk($sformatf("v%0d_wbv", i), wb_valid, vecs[i].exp_wbv);
            chk($sformatf("v%0d_dest", i), wb_destAdd, vecs[i].dest);
            chk($sformatf("v%0d_alu", i), wb_alu_result, vecs[i].alu);
            chk($sformatf("v%0d_rw", i), wb_RegWrite, vecs[i].rw);
            chk($sformatf("v%0d_rdata", i), wb_MemReadData, 0);
            chk($sformatf("v%0d_req", i), dmem_req, 0);
        end
        idle_inputs();
        tick();

        // Load, ack on the 4th WAIT cycle.
        set_op(0, 1, 1, 4'h5, 16'h0040, 16'h0);
        stalls = 0;
        #1;
        chk("ld_idle_req", dmem_req, 0);
        if (stallM) stalls++;
        tick();
        chk("ld_req", dmem_req, 1);
        chk("ld_we", dmem_we, 0);
        chk("ld_addr", dmem_addr, 12'h040);
        chk("ld_wbv_wait", wb_valid, 0);
        for (int i = 0; i < 3; i++) begin
            if (stallM) stalls++;
            tick();
            chk($sformatf("ld_hold_addr%0d", i), dmem_addr, 12'h040);
        end
        dmem_ack = 1; dmem_rdata = 16'hBEEF;
        #1;
        if (stallM) stalls++;
        chk("ld_ack_stall", stallM, 0);
        chk("ld_stall_cnt", stalls, 4);
        tick();
        idle_inputs();
        dmem_rdata = 16'h0;
        chk("ld_req_done", dmem_req, 0);
        chk("ld_wbv", wb_valid, 1);
        chk("ld_rdata", wb_MemReadData, 16'hBEEF);
        chk("ld_mtr", wb_MemToReg, 1);
        chk("ld_dest", wb_destAdd, 4'h5);
        tick();

        // Store, ack on the first WAIT cycle, then back-to-back store with both strobes.
        set_op(1, 0, 0, 4'h6, 16'h0FFF, 16'h00A5);
        #1;
        chk("st_idle_stall", stallM, 1);
        tick();
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 12'hFFF);
        chk("st_wdata", dmem_wdata, 16'h00A5);
        dmem_ack = 1; dmem_rdata = 16'h1111;
        #1;
        chk("st_ack_stall", stallM, 0);
        tick();
        dmem_ack = 0;
        chk("st_wbv", wb_valid, 1);
        chk("st_rw", wb_RegWrite, 0);
        chk("st_rdata", wb_MemReadData, 0);
        chk("st_req_done", dmem_req, 0);
        set_op(1, 1, 0, 4'h8, 16'h0123, 16'h4242);
        #1;
        chk("b2b_idle_stall", stallM, 1);
        chk("b2b_idle_req", dmem_req, 0);
        tick();
        chk("b2b_we", dmem_we, 1);
        chk("b2b_wdata", dmem_wdata, 16'h4242);
        dmem_ack = 1;
        tick();
        idle_inputs();
        chk("b2b_rdata", wb_MemReadData, 0);
        tick();

        // Timeout: never ack.
        set_op(0, 1, 1, 4'h9, 16'h0222, 16'h0);
        dmem_rdata = 16'hDEAD;
        tick();
        reqs = 0;
        for (int i = 0; i < 15; i++) begin
            if (dmem_req) reqs++;
            chk($sformatf("to_stall%0d", i), stallM, (i == 14) ? 1'b0 : 1'b1);
            tick();
        end
        chk("to_req_cnt", reqs, 15);
        chk("to_req_done", dmem_req, 0);
        chk("to_err", mem_err, 1);
        chk("to_wbv", wb_valid, 1);
        chk("to_rw", wb_RegWrite, 0);
        chk("to_rdata", wb_MemReadData, 0);
        set_op(0, 0, 1, 4'h1, 16'h0005, 16'h0);
        tick();
        idle_inputs();
        chk("to_err_sticky", mem_err, 1);
        chk("to_after_wbv", wb_valid, 1);

        // Reset during the second WAIT cycle: request abandoned, error cleared.
        set_op(0, 1, 1, 4'h2, 16'h0333, 16'h0);
        tick();
        tick();
        reset = 0;
        #1;
        chk("rw_stall", stallM, 0);
        tick();
        reset = 1;
        idle_inputs();
        chk("rw_req", dmem_req, 0);
        chk("rw_err", mem_err, 0);
        dmem_ack = 1; dmem_rdata = 16'hCAFE;
        #1;
        chk("stray_stall", stallM, 0);
        tick();
        dmem_ack = 0;
        chk("stray_req", dmem_req, 0);
        chk("stray_wbv", wb_valid, 0);
        chk("stray_rdata", wb_MemReadData, 0);

        // Ack on the final timeout cycle completes normally.
        set_op(0, 1, 1, 4'hA, 16'h0444, 16'h0);
        tick();
        for (int i = 0; i < 14; i++) tick();
        dmem_ack = 1; dmem_rdata = 16'h5A5A;
        #1;
        chk("af_stall", stallM, 0);
        tick();
        idle_inputs();
        chk("af_err", mem_err, 0);
        chk("af_wbv", wb_valid, 1);
        chk("af_rw", wb_RegWrite, 1);
        chk("af_rdata", wb_MemReadData, 16'h5A5A);
        chk("af_req", dmem_req, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
